fetch: RTL and testbench

Front-end fetch stage. It generates sequential instruction addresses and issues them to the instruction memory, then buffers the returned 32-bit instructions in a small fetch queue. It presents those instructions to `decode` as `valid_fe1`/`instr_fe1`, gated by `decode_ready_de0`. On a nuke it redirects to the nuke PC, flushes the queue and discards responses still in flight. There is no branch prediction: after reset or a redirect, the PC advances by 4 per request.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_gen_fifo.sv | 59 +++++
 rtl/fetch.sv | 145 ++++++++++++++
 tb/tb_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: redirect packet from retire and the
// instruction packet handed to decode.
package fetch_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] nuke_pc;
  } t_nuke_pkt;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
`ifdef SIMULATION
    logic [31:0] SIMID;
`endif
  } t_instr_pkt;

  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_gen_fifo.sv
// Single-push / single-pop circular FIFO. Push while full is accepted only
// when a pop happens in the same cycle. Storage is not reset.
module fetch_gen_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int NPUSH = 1,
  parameter int NPOP  = 1,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Only the one-in/one-out configuration is implemented.
  always_ff @(posedge clk) begin
    assert (NPUSH == 1 && NPOP == 1);
  end

endmodule

// File: rtl/fetch.sv
// Front-end fetch: sequential PC generation, credit-limited imem requests,
// fetch queue toward decode, and nuke redirect with in-flight response drop.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          FQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  t_nuke_pkt   nuke_rb1,
  output logic        imem_req_valid_fe0,
  input  logic        imem_req_ready_fe0,
  output logic [63:0] imem_req_addr_fe0,
  input  logic        imem_rsp_valid_fe1,
  input  logic [31:0] imem_rsp_data_fe1,
  input  logic        decode_ready_de0,
  output logic        valid_fe1,
  output t_instr_pkt  instr_fe1
);

  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FQ_DEPTH + 1);
  localparam int IW  = $bits(t_instr_pkt);

  logic [63:0]    pc_fe0;
  logic [OCW-1:0] outstanding;
  logic [OCW-1:0] drop_cnt;
  logic           credit_ok;
  logic           req_fire;
  logic           fq_push;
  logic           fq_reset;
  logic [FCW-1:0] fq_count;
  logic           fq_full;
  logic           fq_empty;
  logic [IW-1:0]  fq_head_bits;
  t_instr_pkt     fq_wr_pkt;
  t_instr_pkt     fq_head;
  logic [63:0]    tag_pc;
  logic [OCW-1:0] tag_count;
  logic           tag_full;
  logic           tag_empty;
`ifdef SIMULATION
  logic [31:0]    simid;
`endif

  // Live responses (not yet marked for drop) plus queued entries may never
  // exceed the FQ, so every response that survives has a slot waiting.
  always_comb begin
    credit_ok = (int'(outstanding) - int'(drop_cnt) + int'(fq_count)) < FQ_DEPTH;
  end

  assign imem_req_valid_fe0 = !reset && !nuke_rb1.valid && credit_ok &&
                              (int'(outstanding) < MAX_OUTSTANDING);
  assign imem_req_addr_fe0  = imem_req_valid_fe0 ? pc_fe0 : '0;
  assign req_fire           = imem_req_valid_fe0 && imem_req_ready_fe0;

  assign fq_push  = imem_rsp_valid_fe1 && (drop_cnt == '0) && !nuke_rb1.valid;
  assign fq_reset = reset || nuke_rb1.valid;

  assign valid_fe1 = !fq_empty && decode_ready_de0 && !nuke_rb1.valid && !reset;
  assign fq_head   = fq_head_bits;
  assign instr_fe1 = valid_fe1 ? fq_head : '0;

  always_comb begin
    fq_wr_pkt       = '0;
    fq_wr_pkt.instr = imem_rsp_data_fe1;
    fq_wr_pkt.pc    = tag_pc;
`ifdef SIMULATION
    fq_wr_pkt.SIMID = simid;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_fe0      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OCW'(req_fire) - OCW'(imem_rsp_valid_fe1);
      if (nuke_rb1.valid) begin
        pc_fe0   <= nuke_rb1.nuke_pc;
        // A response landing in the nuke cycle is already gone, so it is
        // not counted among the responses still to be dropped.
        drop_cnt <= outstanding - OCW'(imem_rsp_valid_fe1);
      end else begin
        if (req_fire) pc_fe0 <= pc_fe0 + PC_STEP;
        if (imem_rsp_valid_fe1 && drop_cnt != '0) drop_cnt <= drop_cnt - OCW'(1);
      end
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (reset)        simid <= '0;
    else if (fq_push) simid <= simid + 32'd1;
  end
`endif

  fetch_gen_fifo #(
    .WIDTH (64),
    .DEPTH (MAX_OUTSTANDING),
    .NPUSH (1),
    .NPOP  (1)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc_fe0),
    .pop       (imem_rsp_valid_fe1),
    .pop_data  (tag_pc),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_gen_fifo #(
    .WIDTH (IW),
    .DEPTH (FQ_DEPTH),
    .NPUSH (1),
    .NPOP  (1)
  ) u_fq (
    .clk       (clk),
    .reset     (fq_reset),
    .push      (fq_push),
    .push_data (fq_wr_pkt),
    .pop       (valid_fe1),
    .pop_data  (fq_head_bits),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (nuke_rb1.valid) assert (nuke_rb1.nuke_pc[1:0] == 2'b00);
      if (imem_rsp_valid_fe1) assert (outstanding != '0 && !tag_empty);
      assert (!(fq_push && fq_full));
      assert (!(req_fire && tag_full));
      assert (tag_count == outstanding);
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order imem model with per-request latency and a
// scoreboard of expected PCs pushed at request acceptance.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [63:0] RPC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset;
  t_nuke_pkt   nuke;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        dec_ready;
  logic        valid_fe1;
  t_instr_pkt  instr;

  always #5 clk = ~clk;

  fetch #(
    .RESET_PC        (RPC),
    .FQ_DEPTH        (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .nuke_rb1           (nuke),
    .imem_req_valid_fe0 (req_valid),
    .imem_req_ready_fe0 (req_ready),
    .imem_req_addr_fe0  (req_addr),
    .imem_rsp_valid_fe1 (rsp_valid),
    .imem_rsp_data_fe1  (rsp_data),
    .decode_ready_de0   (dec_ready),
    .valid_fe1          (valid_fe1),
    .instr_fe1          (instr)
  );

  typedef struct {
    logic [63:0] addr;
    int          t;
  } t_pend;

  t_pend       pend[$];
  logic [63:0] sb[$];
  logic [63:0] model_pc;
  logic [63:0] nuke_target;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          last_rsp_t = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          req_mode = 1;
  int          dec_mode = 1;
  int          n_fire = 0;
  int          n_dlv = 0;
  int          first_valid_rel = 0;
  bit          after_nuke = 0;
  bit          seen_post = 0;
  bit          simid_relax = 0;
  logic [31:0] exp_simid = '0;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    logic [63:0] exp_pc;
    int          lat;
    int          t;
    if (reset) begin
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_req_addr", req_addr, 64'd0);
      chk("rst_valid", 64'(valid_fe1), 64'd0);
      chk("rst_instr_zero", 64'(instr == '0), 64'd1);
      pend.delete();
      sb.delete();
      model_pc    = RPC;
      last_rsp_t  = cyc;
      after_nuke  = 0;
      simid_relax = 0;
      exp_simid   = '0;
      return;
    end
    if (rsp_valid) void'(pend.pop_front());
    if (valid_fe1) begin
      chk("valid_needs_ready", 64'(dec_ready), 64'd1);
      if (first_valid_rel == 0) first_valid_rel = rel_cyc;
      n_dlv++;
      if (sb.size() == 0) begin
        chk("dlv_unexpected", 64'(valid_fe1), 64'd0);
      end else begin
        exp_pc = sb.pop_front();
        chk("dlv_pc", instr.pc, exp_pc);
        chk("dlv_instr", 64'(instr.instr), 64'(mem_word(exp_pc)));
        if (after_nuke) begin
          chk("post_nuke_first_pc", instr.pc, nuke_target);
          after_nuke = 0;
          seen_post  = 1;
        end
`ifdef SIMULATION
        if (simid_relax) chk("simid_incr", 64'(instr.SIMID >= exp_simid), 64'd1);
        else             chk("simid_step", 64'(instr.SIMID), 64'(exp_simid));
        exp_simid   = instr.SIMID + 32'd1;
        simid_relax = 0;
`endif
      end
    end else begin
      chk("idle_instr_zero", 64'(instr == '0), 64'd1);
    end
    if (nuke.valid) begin
      chk("nuke_no_req", 64'(req_valid), 64'd0);
      chk("nuke_no_dlv", 64'(valid_fe1), 64'd0);
      sb.delete();
      model_pc    = nuke.nuke_pc;
      nuke_target = nuke.nuke_pc;
      after_nuke  = 1;
      simid_relax = 1;
    end else if (req_valid) begin
      chk("req_addr", req_addr, model_pc);
      if (req_ready) begin
        lat = int'($urandom_range(lat_min, lat_max));
        t   = cyc + lat;
        if (t <= last_rsp_t) t = last_rsp_t + 1;
        last_rsp_t = t;
        pend.push_back('{addr: model_pc, t: t});
        sb.push_back(model_pc);
        model_pc = model_pc + 64'd4;
        n_fire++;
        chk("max_outstanding", 64'(pend.size() <= 4), 64'd1);
      end
    end
  endtask

  task automatic step(input logic rst, input logic nk, input logic [63:0] npc);
    @(negedge clk);
    reset        = rst;
    nuke.valid   = nk;
    nuke.nuke_pc = nk ? npc : '0;
    req_ready    = (req_mode == 2) ? 1'($urandom_range(0, 1)) : (req_mode != 0);
    dec_ready    = (dec_mode == 2) ? 1'($urandom_range(0, 1)) : (dec_mode != 0);
    if (!rst && pend.size() > 0 && pend[0].t <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    if (rst) rel_cyc = 0;
    else     rel_cyc++;
    #4;
    sample();
    cyc++;
  endtask

  initial begin
    logic [63:0] npc;
    bit          nk;
    reset = 1'b1; nuke = '0; req_ready = 1'b0; dec_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0;

    // Reset start, L=1, decode always ready.
    repeat (3) step(1'b1, 1'b0, '0);
    n_dlv = 0; first_valid_rel = 0;
    repeat (15) step(1'b0, 1'b0, '0);
    chk("p1_first_valid_cycle", 64'(first_valid_rel), 64'd3);
    chk("p1_deliveries", 64'(n_dlv), 64'd13);

    // Decode stalled for 10 cycles with L=2: credit caps requests at 4.
    lat_min = 2; lat_max = 2; dec_mode = 0;
    repeat (2) step(1'b1, 1'b0, '0);
    n_fire = 0;
    repeat (10) step(1'b0, 1'b0, '0);
    chk("p2_requests_while_stalled", 64'(n_fire), 64'd4);
    dec_mode = 1; n_dlv = 0;
    repeat (4) step(1'b0, 1'b0, '0);
    chk("p2_drain_no_gaps", 64'(n_dlv), 64'd4);
    repeat (6) step(1'b0, 1'b0, '0);

    // L=3, nuke with three requests outstanding.
    lat_min = 3; lat_max = 3;
    repeat (2) step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);
    seen_post = 0;
    step(1'b0, 1'b1, 64'h2000);
    repeat (12) step(1'b0, 1'b0, '0);
    chk("p3_post_nuke_seen", 64'(seen_post), 64'd1);

    // Nuke together with an arriving response and a queued entry.
    lat_min = 2; lat_max = 2; dec_mode = 0;
    repeat (2) step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);
    dec_mode = 1; seen_post = 0;
    step(1'b0, 1'b1, 64'h5000);
    repeat (10) step(1'b0, 1'b0, '0);
    chk("p4_post_nuke_seen", 64'(seen_post), 64'd1);

    // Back-to-back nukes with random latency.
    lat_min = 1; lat_max = 4;
    repeat (5) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 64'h3000);
    seen_post = 0;
    step(1'b0, 1'b1, 64'h4000);
    repeat (25) step(1'b0, 1'b0, '0);
    chk("p5_post_nuke_seen", 64'(seen_post), 64'd1);

    // Random request/decode readiness with occasional nukes.
    req_mode = 2; dec_mode = 2; n_dlv = 0;
    for (int i = 0; i < 3000; i++) begin
      nk  = ($urandom_range(0, 99) == 0);
      npc = 64'($urandom_range(0, 32'h0fff_ffff)) << 2;
      step(1'b0, nk, npc);
    end
    chk("p6_progress", 64'(n_dlv > 200), 64'd1);

    // Stop requesting and let everything in flight drain to decode.
    req_mode = 0; dec_mode = 1;
    repeat (20) step(1'b0, 1'b0, '0);
    chk("final_drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
